// File: rtl/pll_lock_seq.sv
// Sequences the PLL hard macro: reset hold, lock qualification, timeout, lock-loss relock, bypass.
// Latency: every output is registered and follows the state reached at the same clock edge.
// Backpressure: cfg_ready_o is low while a sequence is running; the requester holds cfg_valid_i until ready.
//
// Ports:
//   fref_i, rst_n_i       reference clock (rising edge) and async active-low reset
//   cfg_*_i / cfg_ready_o valid/ready config request: dividers plus bypass request
//   lkdt_i                macro lock detect, asynchronous to fref_i
//   pll_*_o               divider, bypass and reset pins of the macro
//   pll_lock_o, busy_o    clock usable / sequence in progress
//   timeout_o, loss_o     sticky lock failure / sticky lock-loss event
//   cfg_err_o             one-cycle pulse when a config is rejected
module pll_lock_seq #(
  parameter int unsigned             RST_CYC      = 16,
  parameter int unsigned             LOCK_CNT_W   = 20,
  parameter logic [LOCK_CNT_W-1:0]   LOCK_CNT_END = 20'h1FFFF,
  parameter logic [LOCK_CNT_W-1:0]   TIMEOUT_END  = 20'hFFFFF,
  parameter bit                      USE_LKDT     = 1'b1,
  parameter int unsigned             LOSS_CYC     = 4,
  parameter logic [7:0]              DEF_REFDIV   = 8'd1,
  parameter logic [11:0]             DEF_FBDIV    = 12'd32,
  parameter logic [3:0]              DEF_POSTDIV1 = 4'd1,
  parameter logic [1:0]              DEF_POSTDIV2 = 2'd0
) (
  input  logic        fref_i,
  input  logic        rst_n_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [7:0]  cfg_refdiv_i,
  input  logic [11:0] cfg_fbdiv_i,
  input  logic [3:0]  cfg_postdiv1_i,
  input  logic [1:0]  cfg_postdiv2_i,
  input  logic        cfg_bp_i,
  input  logic        lkdt_i,
  output logic [7:0]  pll_refdiv_o,
  output logic [11:0] pll_fbdiv_o,
  output logic [3:0]  pll_postdiv1_o,
  output logic [1:0]  pll_postdiv2_o,
  output logic        pll_bp_o,
  output logic        pll_rst_o,
  output logic        pll_lock_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic        loss_o,
  output logic        cfg_err_o
);

  typedef struct packed {
    logic [7:0]  refdiv;
    logic [11:0] fbdiv;
    logic [3:0]  postdiv1;
    logic [1:0]  postdiv2;
  } pll_cfg_t;

  typedef enum logic [2:0] {
    S_PRST, S_WAIT, S_LOCKED, S_FAIL, S_BYPASS
  } state_t;

  localparam int unsigned RST_W  = $clog2(RST_CYC + 1);
  localparam int unsigned LOSS_W = $clog2(LOSS_CYC + 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYC - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_CYC - 1);
  localparam pll_cfg_t CFG_DEF = {DEF_REFDIV, DEF_FBDIV, DEF_POSTDIV1, DEF_POSTDIV2};

  state_t                state_q, state_d;
  logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [LOCK_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [LOSS_W-1:0]     loss_cnt_q, loss_cnt_d;
  pll_cfg_t              cfg_q, cfg_d, cfg_in;
  logic                  timeout_d, loss_d, cfg_err_d;
  logic                  pll_rst_d, pll_bp_d, lock_d, busy_d, ready_d;
  logic                  lkdt_meta, lkdt_sync, lkdt_s;
  logic                  cfg_acc, cfg_bad;

  assign lkdt_s  = USE_LKDT ? lkdt_sync : 1'b1;
  assign cfg_in  = {cfg_refdiv_i, cfg_fbdiv_i, cfg_postdiv1_i, cfg_postdiv2_i};
  assign cfg_acc = cfg_valid_i & cfg_ready_o;
  assign cfg_bad = !cfg_bp_i && (cfg_refdiv_i == 8'd0 || cfg_fbdiv_i == 12'd0);

  assign pll_refdiv_o   = cfg_q.refdiv;
  assign pll_fbdiv_o    = cfg_q.fbdiv;
  assign pll_postdiv1_o = cfg_q.postdiv1;
  assign pll_postdiv2_o = cfg_q.postdiv2;

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = '0;
    lock_cnt_d = lock_cnt_q;
    to_cnt_d   = to_cnt_q;
    loss_cnt_d = loss_cnt_q;
    cfg_d      = cfg_q;
    timeout_d  = timeout_o;
    loss_d     = loss_o;
    cfg_err_d  = 1'b0;

    case (state_q)
      S_PRST: begin
        lock_cnt_d = '0;
        to_cnt_d   = '0;
        loss_cnt_d = '0;
        if (rst_cnt_q == RST_LAST) state_d = S_WAIT;
        else                       rst_cnt_d = rst_cnt_q + RST_W'(1);
      end
      S_WAIT: begin
        to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + LOCK_CNT_W'(1);
        if (!lkdt_s)               lock_cnt_d = '0;
        else if (lock_cnt_q != '1) lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
        // Lock is tested first so a lock on the timeout cycle still wins.
        if (lock_cnt_q == LOCK_CNT_END) begin
          state_d = S_LOCKED;
        end else if (to_cnt_q == TIMEOUT_END) begin
          state_d   = S_FAIL;
          timeout_d = 1'b1;
        end
      end
      S_LOCKED: begin
        if (lkdt_s) begin
          loss_cnt_d = '0;
        end else if (loss_cnt_q == LOSS_LAST) begin
          // Lock lost: re-run the sequence with the config already held.
          state_d    = S_PRST;
          loss_d     = 1'b1;
          loss_cnt_d = '0;
        end else begin
          loss_cnt_d = loss_cnt_q + LOSS_W'(1);
        end
      end
      S_FAIL, S_BYPASS: ;
      default: state_d = S_PRST;
    endcase

    // A handshake is only possible in LOCKED/FAIL/BYPASS and overrides
    // anything the state logic decided above, including lock loss.
    if (cfg_acc) begin
      if (cfg_bad) begin
        state_d    = state_q;
        loss_cnt_d = loss_cnt_q;
        loss_d     = loss_o;
        cfg_err_d  = 1'b1;
      end else if (cfg_bp_i) begin
        state_d   = S_BYPASS;
        cfg_d     = cfg_in;
        timeout_d = 1'b0;
      end else begin
        state_d    = S_PRST;
        cfg_d      = cfg_in;
        rst_cnt_d  = '0;
        loss_cnt_d = '0;
        timeout_d  = 1'b0;
        loss_d     = 1'b0;
      end
    end

    // Outputs are decoded from the next state so they register in step with it.
    pll_rst_d = (state_d == S_PRST) || (state_d == S_FAIL) || (state_d == S_BYPASS);
    pll_bp_d  = (state_d == S_PRST) || (state_d == S_BYPASS);
    lock_d    = (state_d == S_LOCKED) || (state_d == S_BYPASS);
    busy_d    = (state_d == S_PRST) || (state_d == S_WAIT);
    ready_d   = !busy_d;
  end

  always_ff @(posedge fref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_PRST;
      rst_cnt_q   <= '0;
      lock_cnt_q  <= '0;
      to_cnt_q    <= '0;
      loss_cnt_q  <= '0;
      lkdt_meta   <= 1'b0;
      lkdt_sync   <= 1'b0;
      cfg_q       <= CFG_DEF;
      pll_rst_o   <= 1'b1;
      pll_bp_o    <= 1'b1;
      pll_lock_o  <= 1'b0;
      busy_o      <= 1'b1;
      cfg_ready_o <= 1'b0;
      timeout_o   <= 1'b0;
      loss_o      <= 1'b0;
      cfg_err_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      to_cnt_q    <= to_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      lkdt_meta   <= lkdt_i;
      lkdt_sync   <= lkdt_meta;
      cfg_q       <= cfg_d;
      pll_rst_o   <= pll_rst_d;
      pll_bp_o    <= pll_bp_d;
      pll_lock_o  <= lock_d;
      busy_o      <= busy_d;
      cfg_ready_o <= ready_d;
      timeout_o   <= timeout_d;
      loss_o      <= loss_d;
      cfg_err_o   <= cfg_err_d;
    end
  end

endmodule

// File: doc/pll_lock_seq.md
Name: pll_lock_seq

Overview:
- Parametrised PLL control sequencer. Next generation of the existing fixed lock-counter PLL wrapper.
- Owns the divider/bypass/reset pins of the PLL hard macro and programs them from a valid/ready config interface.
- Holds the macro in reset for a programmable time, then qualifies lock with a counter and, optionally, the macro's lock-detect pin.
- Adds behaviour the old wrapper lacked: lock timeout, lock-loss detection with automatic relock, config rejection, and a bypass mode.
- Runs in the reference-clock domain, between the sysctrl register block and the PLL macro.

Parameters:
- RST_CYC, 16: cycles pll_rst_o is held high per sequence (≥1).
- LOCK_CNT_W, 20: width of the lock and timeout counters.
- LOCK_CNT_END, 20'h1FFFF: lock-qualify count.
- TIMEOUT_END, 20'hFFFFF: WAIT cycles before declaring failure; must be > LOCK_CNT_END.
- USE_LKDT, 1: 1 = lock counting is gated by lkdt_i; 0 = pure timer.
- LOSS_CYC, 4: consecutive low synced-lkdt cycles in LOCKED that constitute lock loss.
- DEF_REFDIV, 8'd1; DEF_FBDIV, 12'd32; DEF_POSTDIV1, 4'd1; DEF_POSTDIV2, 2'd0: configuration loaded at reset.

Ports:
- fref_i  in  1  reference clock; all logic runs on its rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- cfg_valid_i  in  1  config request.
- cfg_ready_o  out  1  config accepted when valid & ready.
- cfg_refdiv_i  in  8  reference divider.
- cfg_fbdiv_i  in  12  feedback divider.
- cfg_postdiv1_i  in  4  post divider 1.
- cfg_postdiv2_i  in  2  post divider 2.
- cfg_bp_i  in  1  request bypass mode.
- lkdt_i  in  1  macro lock detect; asynchronous.
- pll_refdiv_o  out  8  to macro.
- pll_fbdiv_o  out  12  to macro.
- pll_postdiv1_o  out  4  to macro.
- pll_postdiv2_o  out  2  to macro.
- pll_bp_o  out  1  macro bypass.
- pll_rst_o  out  1  macro reset, active-high.
- pll_lock_o  out  1  PLL clock usable.
- busy_o  out  1  sequence in progress.
- timeout_o  out  1  sticky lock failure.
- loss_o  out  1  sticky lock-loss event.
- cfg_err_o  out  1  one-cycle pulse: config rejected.

Behaviour:
- All outputs are registered.
- Reset values:
  - State PRST; counters 0; lkdt synchronizer 0.
  - pll_rst_o=1, pll_bp_o=1, pll_lock_o=0, busy_o=1, cfg_ready_o=0.
  - timeout_o=0, loss_o=0, cfg_err_o=0.
  - Divider outputs = DEF_*.
- After reset release, a sequence starts automatically with the default config.
- lkdt_i passes through a 2-flop synchronizer (lkdt_s). USE_LKDT=0 forces lkdt_s=1.
- PRST:
  - pll_rst_o=1, pll_bp_o=1, lock_o=0, busy_o=1; rst_cnt increments.
  - After exactly RST_CYC cycles in PRST -> WAIT, with lock_cnt=0 and to_cnt=0.
- WAIT:
  - pll_rst_o=0, pll_bp_o=0.
  - to_cnt increments every cycle.
  - lock_cnt increments when lkdt_s=1 and clears to 0 when lkdt_s=0.
  - lock_cnt==LOCK_CNT_END -> LOCKED; pll_lock_o=1 on the next cycle.
  - Otherwise, to_cnt==TIMEOUT_END -> FAIL.
  - If both conditions hold in the same cycle, lock wins.
- LOCKED:
  - lock_o=1, busy_o=0, cfg_ready_o=1.
  - loss_cnt counts consecutive lkdt_s=0 cycles and clears on lkdt_s=1.
  - loss_cnt reaching LOSS_CYC -> loss_o=1 (sticky), lock_o=0, go to PRST with the same config (auto relock).
- FAIL: pll_rst_o=1, timeout_o=1, busy_o=0, cfg_ready_o=1, lock_o=0.
- BYPASS: pll_bp_o=1, pll_rst_o=1 (macro powered down), lock_o=1, busy_o=0, cfg_ready_o=1.
- cfg_ready_o=0 in PRST and WAIT. cfg_valid_i is ignored there; the requester holds it.
- Config accept (valid & ready, in LOCKED, FAIL or BYPASS):
  - If cfg_bp_i=0 and (refdiv==0 or fbdiv==0): reject. cfg_err_o=1 for one cycle; state and outputs otherwise unchanged.
  - Else if cfg_bp_i=1: next cycle BYPASS. Dividers are latched but not used. timeout_o cleared.
  - Else: next cycle enter PRST with new dividers driven, lock_o=0, busy_o=1. timeout_o and loss_o cleared.
- Accept during LOCKED takes precedence over lock loss in the same cycle.
- In BYPASS, lkdt_i is ignored.
- Asynchronous reset mid-sequence returns to reset values immediately. Latched config reverts to DEF_*.
- Counters saturate and never wrap. rst_cnt uses $clog2(RST_CYC+1) bits.

Test Plan (RST_CYC=4, LOCK_CNT_END=15, TIMEOUT_END=63, LOSS_CYC=3, lkdt_i tied 1):
- Release reset -> pll_rst_o high for 4 cycles; lock_o rises 16 cycles after WAIT entry. Dividers show 1/32/1/0 throughout.
- In LOCKED, send refdiv=2, fbdiv=100, postdiv1=3, postdiv2=1 -> ready seen, lock_o drops next cycle, pll_rst_o high for 4 cycles, outputs show 2/100/3/1, relock after 16 WAIT cycles.
- lkdt_i held 0 -> after 64 WAIT cycles FAIL: timeout_o=1, pll_rst_o=1, lock_o=0. A valid config then clears timeout_o and restarts the sequence.
- In LOCKED, drop lkdt_i for 2 cycles -> no effect. Drop it for 3 synced cycles -> loss_o=1, lock_o=0, automatic relock with the same dividers.
- Send config with fbdiv=0 -> cfg_err_o pulses for one cycle, lock_o stays 1, dividers unchanged. Send cfg_bp_i=1 -> pll_bp_o=1, pll_rst_o=1, lock_o=1.
- Assert rst_n_i during WAIT -> all outputs at reset values asynchronously, divider outputs back to defaults.
